// File: rtl/i2c_readback_sched_pkg.sv
// Shared constants for the I2C readback scheduler: readback addresses,
// default sizing and the snapshot FSM encoding.
package i2c_sched_pkg;
    localparam int NUM_SRC_DEF = 4;
    localparam int DATA_W_DEF  = 12;

    localparam logic [6:0] VER_ADDR    = 7'h15;
    localparam logic [6:0] PWROUT_ADDR = 7'h16;
    localparam logic [6:0] FWD_ADDR    = 7'h17;
    localparam logic [6:0] REV_ADDR    = 7'h18;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SNAP = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
endpackage

// File: rtl/i2c_readback_sched_if.sv
// Bus between telemetry producers / I2C slave (master side) and the scheduler.
// Handshake: a producer raises src_valid[i] with stable src_data slice i and
// holds both until src_ready[i]; the sample transfers in that same cycle.
interface i2c_readback_sched_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 12
);
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      rd_req;
    logic [6:0]                rd_addr;
    logic                      rd_busy;
    logic [7:0]                tx_hi;
    logic [7:0]                tx_lo;
    logic                      tx_valid;
    logic                      addr_hit;
    logic [1:0]                dbg_state;

    modport master (
        output src_valid, src_data, rd_req, rd_addr, rd_busy,
        input  src_ready, tx_hi, tx_lo, tx_valid, addr_hit, dbg_state
    );
    modport slave (
        input  src_valid, src_data, rd_req, rd_addr, rd_busy,
        output src_ready, tx_hi, tx_lo, tx_valid, addr_hit, dbg_state
    );
endinterface

// File: rtl/i2c_readback_sched_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle searching upward from the pointer;
// the pointer moves past the winner and holds when nothing is granted.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  i_req,
    input  logic          i_adv,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx
);
    logic [IW-1:0] r_ptr;
    logic          w_found;
    logic [IW-1:0] w_idx;
    int            w_j;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= N) w_j = w_j - N;
            if (!w_found && i_req[IW'(w_j)]) begin
                w_found = 1'b1;
                w_idx   = IW'(w_j);
            end
        end
    end

    always_comb begin
        o_gnt = '0;
        if (w_found && i_adv) o_gnt[w_idx] = 1'b1;
    end

    assign o_gnt_idx = w_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_found && i_adv) begin
            r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_readback_sched.sv
// Shadow bank filled by a round-robin arbiter; each I2C read address match
// captures one coherent 16-bit snapshot that stays frozen for the transfer.
module i2c_readback_sched
    import i2c_sched_pkg::*;
#(
    parameter int         NUM_SRC   = NUM_SRC_DEF,
    parameter int         DATA_W    = DATA_W_DEF,
    parameter logic [6:0] ADDR_BASE = VER_ADDR
) (
    input logic                 CLK,
    input logic                 reset,
    i2c_readback_sched_if.slave bus
);
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [DATA_W-1:0]  r_bank [NUM_SRC];
    logic [NUM_SRC-1:0] r_fresh;
    logic [1:0]         r_state;
    logic [7:0]         r_snap_hi, r_snap_lo;
    logic               r_snap_hit;
    logic [7:0]         r_tx_hi, r_tx_lo;
    logic               r_tx_valid, r_addr_hit;

    logic [NUM_SRC-1:0] w_gnt;
    logic [IW-1:0]      w_gnt_idx;
    logic [DATA_W-1:0]  w_gnt_data;
    logic [6:0]         w_offs;
    logic               w_hit;
    logic [IW-1:0]      w_k;
    logic               w_bypass;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_sel_fresh;
    logic [15:0]        w_data16;
    logic               w_start;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk       (CLK),
        .reset     (reset),
        .i_req     (bus.src_valid),
        .i_adv     (~reset),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    // Wrapped subtraction lands far above NUM_SRC, so one compare covers both ends.
    assign w_offs     = bus.rd_addr - ADDR_BASE;
    assign w_hit      = (w_offs < 7'(NUM_SRC));
    assign w_k        = w_offs[IW-1:0];
    assign w_gnt_data = bus.src_data[int'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_bypass   = (|w_gnt) && (w_gnt_idx == w_k);
    assign w_start    = (r_state == ST_IDLE) && bus.rd_req;

    always_comb begin
        w_sel_data  = '0;
        w_sel_fresh = 1'b0;
        if (w_bypass) begin
            w_sel_data  = w_gnt_data;
            w_sel_fresh = 1'b1;
        end else if (w_hit) begin
            w_sel_data  = r_bank[w_k];
            w_sel_fresh = r_fresh[w_k];
        end
    end

    assign w_data16 = 16'(w_sel_data);

    // Snapshot clear is ordered after the grant write so it wins on bypass.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) r_bank[i] <= '0;
            r_fresh <= '0;
        end else begin
            if (|w_gnt) begin
                r_bank[w_gnt_idx]  <= w_gnt_data;
                r_fresh[w_gnt_idx] <= 1'b1;
            end
            if (w_start && w_hit) r_fresh[w_k] <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_snap_hi  <= '0;
            r_snap_lo  <= '0;
            r_snap_hit <= 1'b0;
            r_tx_hi    <= '0;
            r_tx_lo    <= '0;
            r_tx_valid <= 1'b0;
            r_addr_hit <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.rd_req) begin
                        r_state    <= ST_SNAP;
                        r_snap_hi  <= w_hit ? {w_sel_fresh, w_data16[14:8]} : 8'h00;
                        r_snap_lo  <= w_hit ? w_data16[7:0] : 8'h00;
                        r_snap_hit <= w_hit;
                    end
                end
                ST_SNAP: begin
                    r_state    <= ST_HOLD;
                    r_tx_hi    <= r_snap_hi;
                    r_tx_lo    <= r_snap_lo;
                    r_addr_hit <= r_snap_hit;
                    r_tx_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (!bus.rd_busy) begin
                        r_state    <= ST_IDLE;
                        r_tx_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.src_ready = w_gnt;
    assign bus.tx_hi     = r_tx_hi;
    assign bus.tx_lo     = r_tx_lo;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.addr_hit  = r_addr_hit;
    assign bus.dbg_state = r_state;
endmodule

// File: doc/i2c_readback_sched.md
Name: i2c_readback_sched

Overview:
- Scheduler/arbiter between the telemetry producers (version, Penny power out, FWD, REV ADC values) and the I2C slave transmit registers.
- Maintains a shadow bank with one entry per readback address, filled by a round-robin arbiter across producers.
- On each I2C address match, it captures one coherent 16-bit snapshot into the high/low transmit bytes and freezes them for the whole transfer.
- Sits between the ADC/telemetry logic and the I2C slave inside the I2C top level.

Parameters:
- NUM_SRC, 4, number of producers and shadow entries; entry i serves address ADDR_BASE+i.
- DATA_W, 12, producer data width; legal range 8..15.
- ADDR_BASE, 7'h15, I2C slave address of entry 0.

Ports:
- CLK  in  1  system clock, 12.288 MHz.
- reset  in  1  synchronous reset, active-high.
- src_valid  in  NUM_SRC  producer i has a new sample.
- src_data  in  NUM_SRC*DATA_W  producer i data occupies bits [i*DATA_W +: DATA_W].
- src_ready  out  NUM_SRC  one-hot grant; the sample is accepted in this cycle.
- rd_req  in  1  one-cycle pulse from the I2C slave on a read address match.
- rd_addr  in  7  address of the matched read, valid with rd_req.
- rd_busy  in  1  high while the I2C byte transfer is in progress.
- tx_hi  out  8  transmit high byte.
- tx_lo  out  8  transmit low byte.
- tx_valid  out  1  the snapshot is loaded and frozen.
- addr_hit  out  1  the last rd_addr fell within ADDR_BASE..ADDR_BASE+NUM_SRC-1.

Behaviour:
- Reset values:
  - All shadow entries 0 and all fresh bits 0.
  - Arbiter pointer 0; src_ready 0.
  - tx_hi = tx_lo = 0; tx_valid = 0; addr_hit = 0; FSM in IDLE.
- Reset mid-transfer aborts the snapshot immediately.
- Arbitration:
  - Round-robin starting at the pointer; at most one grant per cycle.
  - src_ready[i] is combinational: src_valid[i] AND selected; it is never high while reset is high.
  - On a grant to i, entry i <= src_data slice and fresh[i] <= 1.
  - The pointer then moves to (i+1) mod NUM_SRC; with no grant it holds.
  - Producers hold valid and data stable until ready.
  - Arbitration runs in every FSM state; a transfer never stalls producers.
- FSM states: IDLE, SNAP, HOLD.
  - IDLE: rd_req = 1 goes to SNAP.
  - SNAP: lasts exactly one cycle, then goes to HOLD.
  - HOLD: stays while rd_busy = 1; goes to IDLE on the first cycle rd_busy = 0.
  - rd_req in SNAP or HOLD is ignored and the tx registers stay frozen.
- Snapshot latency and content:
  - rd_req sampled at edge N; tx_hi/tx_lo/addr_hit are valid after edge N+1; tx_valid rises at the same time.
  - tx_valid stays high through HOLD and clears on the return to IDLE; tx_hi/tx_lo hold their last value.
  - Hit: tx_hi = {fresh[k], zero pad, data[DATA_W-1:8]} and tx_lo = data[7:0], where k = rd_addr-ADDR_BASE.
  - Miss: tx_hi = tx_lo = 0 and addr_hit = 0.
- Simultaneous events:
  - If the arbiter writes entry k in the same cycle as the rd_req for k, the snapshot bypasses the bank and returns the new data with fresh = 1.
  - On a snapshot of entry k, fresh[k] <= 0, including the bypass case.
  - A write to entry k in a later cycle sets fresh[k] again but does not change the frozen tx registers.
- Width: address subtraction is 7-bit unsigned; any out-of-range or wrapped result counts as a miss.

Decomposition:
- Package i2c_sched_pkg holds:
  - The address constants VER_ADDR 7'h15, PWROUT_ADDR 7'h16, FWD_ADDR 7'h17, REV_ADDR 7'h18.
  - The FSM state encoding IDLE/SNAP/HOLD.
  - NUM_SRC_DEF and DATA_W_DEF.
- One sub-module, rr_arbiter (parameter N).
  - Inputs: request vector, advance enable.
  - Outputs: one-hot grant and grant index; it owns the pointer register.
- Bank, FSM and snapshot mux stay in i2c_readback_sched.

Test Plan:
- Reset, then rd_req with rd_addr = 7'h17 and no writes -> after edge N+1: tx_hi = 8'h00, tx_lo = 8'h00, addr_hit = 1, tx_valid = 1.
- src_valid = 4'b1111 held for 4 cycles with data 12'h0A5, 12'h3C4, 12'h812, 12'hFFF -> grants 0,1,2,3 in order, one per cycle. Then rd_req at 7'h16 -> tx_hi = 8'h83, tx_lo = 8'hC4. A second read at 7'h16 -> tx_hi = 8'h03 (fresh cleared).
- In the same cycle, a grant to entry 2 with 12'h5A7 and rd_req at 7'h17 -> tx_hi = 8'h85, tx_lo = 8'hA7; fresh[2] = 0 afterwards.
- With rd_busy = 1 in HOLD, apply a new write to entry 3 and a second rd_req -> tx_hi/tx_lo unchanged and tx_valid stays 1. Drop rd_busy -> IDLE with tx_valid = 0 next cycle.
- rd_req at 7'h14 and at 7'h19 -> addr_hit = 0, tx_hi = tx_lo = 8'h00. Also rd_req at 7'h7F -> miss.
- Assert reset during HOLD while src_valid = 4'b0101 -> src_ready = 0 during reset. The next cycle shows IDLE, tx_valid = 0, all entries 0, and the first grant after release goes to source 0.
